// File: rtl/nlprg_pkg.sv
// Shared definitions for the 16-bit nonlinear pattern generator and its checker.
// Holds the word width, the full sequence period, the checker state encoding
// and the generator next-state function.
package nlprg_pkg;

  localparam int NLPRG_W      = 16;
  localparam int NLPRG_PERIOD = 65536;

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } nlprg_state_e;

  // Shift of w[14:5] into the top, nonlinear taps into the low six bits.
  // The Z term splices the all-zero-high state into the cycle so the
  // sequence covers every 16-bit value.
  function automatic logic [NLPRG_W-1:0] nlprg_next(input logic [NLPRG_W-1:0] w);
    logic [NLPRG_W-1:0] n;
    logic               z;
    z        = (&w[3:0]) & ~(|w[15:5]);
    n[15:6]  = w[14:5];
    n[0]     = ~(w[14] ^ w[15] ^ w[5]);
    n[1]     = w[12] ^ w[13] ^ w[0];
    n[2]     = w[10] ^ w[11] ^ w[1];
    n[3]     = w[8]  ^ w[9]  ^ w[2];
    n[4]     = w[6]  ^ w[7]  ^ w[3];
    n[5]     = ~(w[7] ^ w[4]) ^ z;
    return n;
  endfunction

endpackage

// File: rtl/nlprg_next_state.sv
// Combinational generator next-state function.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
module nlprg_next_state
  import nlprg_pkg::*;
(
  input  logic [NLPRG_W-1:0] w_i,
  output logic [NLPRG_W-1:0] n_o
);

  assign n_o = nlprg_next(w_i);

endmodule

// File: rtl/nlprg16_checker.sv
// Pattern checker: locks onto the generator stream, counts mismatches, verifies period.
// Latency: all outputs registered, one cycle after the sampled word.
// Backpressure: none; in_valid low freezes all state. Macro NLPRG_CHK_FIRST_ERR_EN enables first-error capture.
module nlprg16_checker
  import nlprg_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NLPRG_W-1:0] in_word,
  input  logic               in_valid,
  input  logic               clr_counts,
  output logic               locked,
  output logic               mismatch,
  output logic [ERR_W-1:0]   err_count,
  output logic               period_seen,
  output logic               period_ok,
  output logic [NLPRG_W-1:0] first_exp,
  output logic [NLPRG_W-1:0] first_obs
);

  localparam logic [3:0]       CNT_LOCK = 4'(LOCK_CNT);
  localparam logic [3:0]       CNT_LOSS = 4'(LOSS_CNT);
  localparam logic [16:0]      PER_MAX  = '1;
  localparam logic [16:0]      PER_LAST = 17'(NLPRG_PERIOD - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  nlprg_state_e        state_q, state_d;
  logic [NLPRG_W-1:0]  pred_q, pred_d;
  logic [NLPRG_W-1:0]  marker_q, marker_d;
  logic [3:0]          match_cnt_q, match_cnt_d;
  logic [3:0]          miss_cnt_q, miss_cnt_d;
  logic [16:0]         per_cnt_q, per_cnt_d;
  logic                locked_q, locked_d;
  logic                mismatch_q, mismatch_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                per_seen_q, per_seen_d;
  logic                per_ok_q, per_ok_d;

  logic [NLPRG_W-1:0]  nxt_obs;
  logic [NLPRG_W-1:0]  nxt_fly;
  logic                hit;
  logic                lock_miss;

  // Observed path re-seeds from the incoming word; flywheel path runs from the prediction.
  nlprg_next_state u_next_obs (.w_i(in_word), .n_o(nxt_obs));
  nlprg_next_state u_next_fly (.w_i(pred_q),  .n_o(nxt_fly));

  assign hit       = (in_word == pred_q);
  assign lock_miss = in_valid && (state_q == LOCKED) && !hit;

  // Next-state: acquisition, flywheel tracking, error and period accounting.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    marker_d    = marker_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    per_cnt_d   = per_cnt_q;
    mismatch_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    per_seen_d  = per_seen_q;
    per_ok_d    = per_ok_q;
    if (in_valid) begin
      unique case (state_q)
        SEED: begin
          pred_d      = nxt_obs;
          match_cnt_d = '0;
          state_d     = ACQUIRE;
        end
        ACQUIRE: begin
          // Always re-seed from the observed word so acquisition self-synchronises.
          pred_d = nxt_obs;
          if (hit) begin
            if (match_cnt_q + 4'd1 == CNT_LOCK) begin
              state_d     = LOCKED;
              marker_d    = in_word;
              per_cnt_d   = '0;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end else begin
            match_cnt_d = '0;
            mismatch_d  = 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel: prediction ignores the observed word so one bad word costs one mismatch.
          pred_d = nxt_fly;
          if (per_cnt_q != PER_MAX) begin
            per_cnt_d = per_cnt_q + 17'd1;
          end
          if ((in_word == marker_q) && (per_cnt_q != '0)) begin
            per_seen_d = 1'b1;
            per_ok_d   = (per_cnt_q == PER_LAST);
            per_cnt_d  = '0;
          end
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            mismatch_d = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (miss_cnt_q + 4'd1 == CNT_LOSS) begin
              state_d     = ACQUIRE;
              match_cnt_d = '0;
              pred_d      = nxt_obs;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end
    // Clear has priority over a same-cycle increment.
    if (clr_counts) begin
      err_cnt_d  = '0;
      per_seen_d = 1'b0;
      per_ok_d   = 1'b0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= SEED;
      pred_q      <= '0;
      marker_q    <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      per_cnt_q   <= '0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
      per_seen_q  <= 1'b0;
      per_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      marker_q    <= marker_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      per_cnt_q   <= per_cnt_d;
      locked_q    <= locked_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
      per_seen_q  <= per_seen_d;
      per_ok_q    <= per_ok_d;
    end
  end

  assign locked      = locked_q;
  assign mismatch    = mismatch_q;
  assign err_count   = err_cnt_q;
  assign period_seen = per_seen_q;
  assign period_ok   = per_ok_q;

`ifdef NLPRG_CHK_FIRST_ERR_EN
  logic               first_vld_q;
  logic [NLPRG_W-1:0] first_exp_q;
  logic [NLPRG_W-1:0] first_obs_q;

  // Capture prediction and observation of the first locked-state mismatch.
  always_ff @(posedge CLK) begin
    if (RST || clr_counts) begin
      first_vld_q <= 1'b0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else if (lock_miss && !first_vld_q) begin
      first_vld_q <= 1'b1;
      first_exp_q <= pred_q;
      first_obs_q <= in_word;
    end
  end

  assign first_exp = first_exp_q;
  assign first_obs = first_obs_q;
`else
  logic unused_lock_miss;
  assign unused_lock_miss = lock_miss;
  assign first_exp        = '0;
  assign first_obs        = '0;
`endif

endmodule

// File: tb/tb_nlprg16_checker.sv
// Testbench for nlprg16_checker: directed streams with queued expectations.
// Stimulus pushes expected mismatch events and status snapshots; a monitor
// process compares them against the DUT on the falling clock edge.
module tb_nlprg16_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] in_word = 16'h0000;
  logic        in_valid = 1'b0;
  logic        clr_counts = 1'b0;
  logic        locked;
  logic        mismatch;
  logic [15:0] err_count;
  logic        period_seen;
  logic        period_ok;
  logic [15:0] first_exp;
  logic [15:0] first_obs;

`ifdef NLPRG_CHK_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  nlprg16_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_word(in_word), .in_valid(in_valid),
    .clr_counts(clr_counts), .locked(locked), .mismatch(mismatch),
    .err_count(err_count), .period_seen(period_seen), .period_ok(period_ok),
    .first_exp(first_exp), .first_obs(first_obs)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        lk;
    logic [15:0] err;
  } mis_t;

  typedef struct {
    string       name;
    logic        lk;
    logic [15:0] err;
    logic        ps;
    logic        pok;
    logic        cf;
    logic [15:0] fe;
    logic [15:0] fo;
  } stat_t;

  mis_t  mis_q[$];
  stat_t stat_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [15:0] g;       // next generator word to send
  logic [15:0] marker;  // word sampled when lock is declared
  logic [15:0] exp_fe;
  logic [15:0] exp_fo;

  // Reference generator written straight from the bit equations.
  function automatic logic [15:0] gen_next(input logic [15:0] w);
    logic [15:0] r;
    logic        zz;
    zz = (w[3:0] == 4'hF) && (w[15:5] == 11'd0);
    r  = {w[14:5], 6'b0};
    r[0] = ~(w[14] ^ w[15] ^ w[5]);
    r[1] = w[12] ^ w[13] ^ w[0];
    r[2] = w[10] ^ w[11] ^ w[1];
    r[3] = w[8] ^ w[9] ^ w[2];
    r[4] = w[6] ^ w[7] ^ w[3];
    r[5] = ~(w[7] ^ w[4]) ^ zz;
    return r;
  endfunction

  task automatic step(input logic [15:0] w, input logic v, input logic c,
                      input logic em, input string nm, input logic [15:0] eerr, input logic elk);
    mis_t m;
    in_word    = w;
    in_valid   = v;
    clr_counts = c;
    @(posedge CLK);
    #1;
    in_valid   = 1'b0;
    clr_counts = 1'b0;
    if (em) begin
      m.name = nm;
      m.err  = eerr;
      m.lk   = elk;
      mis_q.push_back(m);
    end
  endtask

  task automatic feed_gen(input int n);
    for (int i = 0; i < n; i++) begin
      step(g, 1'b1, 1'b0, 1'b0, "", 16'd0, 1'b0);
      g = gen_next(g);
    end
  endtask

  task automatic expect_stat(input string nm, input logic lk, input logic [15:0] err,
                             input logic ps, input logic pok, input logic cf,
                             input logic [15:0] fe, input logic [15:0] fo);
    stat_t s;
    s.name = nm; s.lk = lk; s.err = err; s.ps = ps; s.pok = pok;
    s.cf = cf; s.fe = fe; s.fo = fo;
    stat_q.push_back(s);
  endtask

  // Monitor: consume expected mismatch events and status snapshots.
  always @(negedge CLK) begin
    mis_t  m;
    stat_t s;
    if (mis_q.size() > 0) begin
      m = mis_q.pop_front();
      checks++;
      if (mismatch !== 1'b1 || err_count !== m.err || locked !== m.lk) begin
        errors++;
        $display("FAIL %s: mismatch=%b err_count=%0d locked=%b, expected mismatch=1 err_count=%0d locked=%b",
                 m.name, mismatch, err_count, locked, m.err, m.lk);
      end
    end else if (mismatch === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_mismatch: mismatch=1 err_count=%0d at %0t, expected mismatch=0",
               err_count, $time);
    end
    while (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      checks++;
      if (locked !== s.lk || err_count !== s.err || period_seen !== s.ps ||
          period_ok !== s.pok || (s.cf && (first_exp !== s.fe || first_obs !== s.fo))) begin
        errors++;
        $display("FAIL %s: locked=%b err=%0d seen=%b ok=%b fexp=%h fobs=%h, expected locked=%b err=%0d seen=%b ok=%b fexp=%h fobs=%h",
                 s.name, locked, err_count, period_seen, period_ok, first_exp, first_obs,
                 s.lk, s.err, s.ps, s.pok, s.fe, s.fo);
      end
    end
  end

  initial begin
    logic [15:0] p;
    // Reset state
    RST = 1'b1;
    step(16'h0, 1'b0, 1'b0, 1'b0, "", 16'd0, 1'b0);
    step(16'h0, 1'b0, 1'b0, 1'b0, "", 16'd0, 1'b0);
    expect_stat("reset_state", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    RST = 1'b0;

    // Acquire from the generator reset value; lock after 1 + 4 samples
    g = 16'h0000;
    feed_gen(4);
    expect_stat("not_locked_after_4", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    marker = g;
    feed_gen(1);
    expect_stat("locked_after_5", 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);

    // Full period: marker recurs exactly 65536 samples later
    feed_gen(65535);
    expect_stat("period_not_yet", 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    feed_gen(1);
    expect_stat("period_full", 1'b1, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);
    feed_gen(8);
    expect_stat("period_sticky", 1'b1, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);

    // Invalid cycles freeze everything, junk on in_word ignored
    for (int i = 0; i < 10; i++) step(16'hFFFF, 1'b0, 1'b0, 1'b0, "", 16'd0, 1'b0);
    expect_stat("pause_hold", 1'b1, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);
    feed_gen(3);
    expect_stat("pause_resume", 1'b1, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);

    // Single bit-3 flip while locked: exactly one mismatch
    exp_fe = FE_EN ? g : 16'h0;
    exp_fo = FE_EN ? (g ^ 16'h0008) : 16'h0;
    step(g ^ 16'h0008, 1'b1, 1'b0, 1'b1, "bitflip_pulse", 16'd1, 1'b1);
    g = gen_next(g);
    feed_gen(3);
    expect_stat("bitflip_after", 1'b1, 16'd1, 1'b1, 1'b1, 1'b1, exp_fe, exp_fo);

    // Clear counts on a good word, lock retained
    step(g, 1'b1, 1'b1, 1'b0, "", 16'd0, 1'b0);
    g = gen_next(g);
    expect_stat("clr_counts", 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);

    // Early marker recurrence: period seen but not the right length
    if (g == marker) begin
      errors++;
      $display("FAIL marker_precondition: next word %h equals marker %h, expected different", g, marker);
    end
    exp_fe = FE_EN ? g : 16'h0;
    exp_fo = FE_EN ? marker : 16'h0;
    step(marker, 1'b1, 1'b0, 1'b1, "marker_inject_pulse", 16'd1, 1'b1);
    g = gen_next(g);
    expect_stat("period_short", 1'b1, 16'd1, 1'b1, 1'b0, 1'b1, exp_fe, exp_fo);
    feed_gen(3);

    // Clear coincident with a mismatch: clear wins
    step(g ^ 16'h0100, 1'b1, 1'b1, 1'b1, "clr_vs_mismatch_pulse", 16'd0, 1'b1);
    g = gen_next(g);
    expect_stat("clr_vs_mismatch", 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    feed_gen(2);

    // Constant 0xFFFF while locked: three counted mismatches then lock lost
    p = g;
    for (int i = 0; i < 3; i++) begin
      if (p == 16'hFFFF) begin
        errors++;
        $display("FAIL ffff_precondition: flywheel word %h, expected not FFFF", p);
      end
      p = gen_next(p);
    end
    step(16'hFFFF, 1'b1, 1'b0, 1'b1, "ffff_miss1", 16'd1, 1'b1);
    step(16'hFFFF, 1'b1, 1'b0, 1'b1, "ffff_miss2", 16'd2, 1'b1);
    step(16'hFFFF, 1'b1, 1'b0, 1'b1, "ffff_miss3", 16'd3, 1'b0);
    for (int i = 0; i < 4; i++) step(16'hFFFF, 1'b1, 1'b0, 1'b1, "ffff_acquire_miss", 16'd3, 1'b0);
    expect_stat("ffff_lost", 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reacquire: first word misses (pred FFFE), then four matches relock
    g = 16'h0000;
    step(g, 1'b1, 1'b0, 1'b1, "reacq_first_miss", 16'd3, 1'b0);
    g = gen_next(g);
    feed_gen(3);
    expect_stat("reacq_3", 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    feed_gen(1);
    expect_stat("reacq_locked", 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset while locked
    RST = 1'b1;
    step(g, 1'b1, 1'b0, 1'b0, "", 16'd0, 1'b0);
    expect_stat("reset_locked", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    RST = 1'b0;
    feed_gen(4);
    expect_stat("after_reset_seed", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    feed_gen(1);
    expect_stat("after_reset_lock", 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);

    repeat (3) @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nlprg16_checker.md
Name: nlprg16_checker

Overview:
- Downstream monitor for the 16-bit nonlinear pattern generator; samples the generator's 16-bit state word each valid cycle.
- Independently predicts the next word using the same next-state function, acquires lock, counts mismatches and verifies the full 65536-cycle period.
- Used in BIST/loopback paths to qualify the pattern stream after transport.

Parameters:
LOCK_CNT, 4, consecutive correct predictions required in ACQUIRE to declare lock (1..15)
LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (1..15)
ERR_W, 16, width of saturating error counter

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
in_word  input  16  sampled generator state word
in_valid  input  1  in_word valid this cycle; no valid means state and counters hold
clr_counts  input  1  synchronous clear of err_count, period_seen, period_ok; lock state untouched
locked  output  1  checker in LOCKED state
mismatch  output  1  one-cycle pulse, registered, for a failed comparison
err_count  output  ERR_W  saturating count of LOCKED-state mismatches
period_seen  output  1  sticky; marker word recurred after lock
period_ok  output  1  sticky; valid only with period_seen; recurrence distance was exactly 65536
first_exp  output  16  expected word of first LOCKED mismatch (optional feature)
first_obs  output  16  observed word of first LOCKED mismatch (optional feature)

Behaviour:
- Reset (RST=1 at an edge): state=SEED; all outputs 0; internal pred, marker, match_cnt, miss_cnt, per_cnt cleared. Reset mid-operation abandons lock immediately.
- next(w) is the generator function:
  - n[15:6] = w[14:5]
  - n0 = ~(w14^w15^w5)
  - n1 = w12^w13^w0
  - n2 = w10^w11^w1
  - n3 = w8^w9^w2
  - n4 = w6^w7^w3
  - n5 = ~(w7^w4) ^ Z, where Z = &w[3:0] & ~|w[15:5]
  - Examples: next(0x0000)=0x0021, next(0x0021)=0x0062.
- SEED: on valid, pred<=next(in_word); go to ACQUIRE.
- ACQUIRE (self-synchronising): on valid, compare in_word to pred; pred<=next(in_word) always.
  - Match: match_cnt++; on reaching LOCK_CNT, go to LOCKED, marker<=in_word, per_cnt<=0, miss_cnt<=0.
  - Mismatch: match_cnt<=0, mismatch pulses; err_count not incremented.
- LOCKED (flywheel): on valid, pred<=next(pred) independent of in_word, so an isolated bit error gives exactly one mismatch.
  - Mismatch: mismatch=1, err_count++ (saturates at all-ones), miss_cnt++.
  - Match: miss_cnt<=0.
  - miss_cnt reaching LOSS_CNT: go to ACQUIRE with match_cnt=0, pred<=next(in_word); locked falls next cycle.
- locked is registered: rises the cycle after the LOCK_CNT-th match is sampled.
- Period check (LOCKED only): per_cnt (17 bit, saturating) increments each valid cycle. When in_word==marker and per_cnt!=0: period_seen<=1, period_ok<=(per_cnt+1==65536), per_cnt<=0, marker kept.
- Simultaneous clr_counts and mismatch: clear wins; err_count=0 that cycle.
- in_valid=0: nothing advances, mismatch=0.

Optional Feature:
- Macro NLPRG_CHK_FIRST_ERR_EN.
- Defined: first LOCKED mismatch captures pred into first_exp and in_word into first_obs; the capture holds until clr_counts or RST.
- Undefined: no capture registers; first_exp/first_obs tied 0.

Decomposition:
- Package nlprg_pkg:
  - NLPRG_W=16
  - NLPRG_PERIOD=65536
  - state enum {SEED, ACQUIRE, LOCKED}
  - function nlprg_next(w)
- One sub-module, nlprg_next_state: combinational wrapper of nlprg_next, instanced twice (observed path and flywheel path).

Test Plan:
- Drive generator from reset (0x0000, 0x0021, 0x0062, ...) with in_valid=1 → locked=1 after 1+LOCK_CNT samples; err_count=0.
- Run locked stream 65536+8 cycles → period_seen=1, period_ok=1; feed a stream with one word skipped → period_ok=0.
- Flip bit 3 of a single word while locked → exactly one mismatch pulse; err_count=1; locked stays 1; with macro, first_obs = first_exp ^ 0x0008.
- Replace stream with constant 0xFFFF while locked → 3 mismatches, then locked=0; err_count=3; no further increments in ACQUIRE.
- Hold in_valid=0 for 10 cycles mid-stream, then resume the sequence where it paused → no mismatch, counters unchanged.
- Assert RST while locked, and separately clr_counts coincident with a mismatch → RST gives all outputs 0 and state SEED; clr_counts gives err_count=0 and locked retained.
